// File: rtl/bus_receiver_if.sv
// bus_receiver_if
// Groups the datapath bus signals seen by the bus receiver into one bundle.
//   bus_value       resolved 8-bit bus value from the bus resolver
//   bus_driven      at least one driver is enabled this cycle
//   precharge       precharge request for the node this cycle
//   load            capture the effective node value at the next edge
//   effective_value combinational value seen on the node this cycle
//   latch_value     registered captured value
//   latch_valid     a load has happened since reset
//   node_state      0=PRECHARGED, 1=DRIVEN, 2=HOLD, 3=DECAYED
//   stale_load      one-cycle pulse: last load sampled a decayed node
// The master modport is the bus side (resolver plus consumer control), the
// slave modport is the receiver itself.
interface bus_receiver_if;
  logic [7:0] bus_value;
  logic       bus_driven;
  logic       precharge;
  logic       load;
  logic [7:0] effective_value;
  logic [7:0] latch_value;
  logic       latch_valid;
  logic [1:0] node_state;
  logic       stale_load;

  modport master (
    output bus_value, bus_driven, precharge, load,
    input  effective_value, latch_value, latch_valid, node_state, stale_load
  );

  modport slave (
    input  bus_value, bus_driven, precharge, load,
    output effective_value, latch_value, latch_valid, node_state, stale_load
  );
endinterface

// File: rtl/bus_receiver.sv
// bus_receiver
// Sink end of the internal 6502 datapath bus. Models the dynamic bus node:
// a driven value is retained for a bounded number of undriven cycles and
// then decays, the node can be precharged to a fixed level, and a load
// latch captures the node value for downstream consumers. Loads taken from
// a decayed node are flagged.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    bus_receiver_if.slave (see interface file for signal list)
module bus_receiver #(
  parameter int         DECAY_CYCLES    = 8,
  parameter logic [7:0] DECAY_VALUE     = 8'h00,
  parameter logic [7:0] PRECHARGE_VALUE = 8'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_receiver_if.slave  bus
);

  localparam int CNT_W = (DECAY_CYCLES < 1) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DECAY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    PRECHARGED = 2'd0,
    DRIVEN     = 2'd1,
    HOLD       = 2'd2,
    DECAYED    = 2'd3
  } node_state_t;

  node_state_t      r_state;
  node_state_t      w_stateNext;
  logic [7:0]       r_held;
  logic [7:0]       w_heldNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_cntBase;
  logic [CNT_W-1:0] w_cntInc;
  logic [7:0]       r_latchValue;
  logic             r_latchValid;
  logic             r_staleLoad;
  logic [7:0]       w_effective;

  // A driver overrides the node immediately; otherwise the node shows the
  // retained charge. Precharge only changes the node at the next edge.
  assign w_effective = bus.bus_driven ? bus.bus_value : r_held;

  // The counter holds the number of completed undriven cycles since the last
  // drive, so the DRIVEN->HOLD step counts as the first one. The value
  // decays at the edge that completes the DECAY_CYCLES-th undriven cycle,
  // which keeps it readable through cycle t+DECAY_CYCLES and shows the decay
  // value from cycle t+DECAY_CYCLES+1. With DECAY_CYCLES=1 this means the
  // node goes straight from DRIVEN to DECAYED.
  always_comb begin
    w_stateNext = r_state;
    w_heldNext  = r_held;
    w_cntNext   = r_cnt;
    w_cntBase   = (r_state == DRIVEN) ? '0 : r_cnt;
    w_cntInc    = (w_cntBase == CNT_MAX) ? w_cntBase : w_cntBase + CNT_W'(1);

    if (bus.bus_driven) begin
      w_heldNext  = bus.bus_value;
      w_stateNext = DRIVEN;
      w_cntNext   = '0;
    end else if (bus.precharge) begin
      w_heldNext  = PRECHARGE_VALUE;
      w_stateNext = PRECHARGED;
      w_cntNext   = '0;
    end else if (r_state == DRIVEN || r_state == HOLD) begin
      if (DECAY_CYCLES == 0) begin
        // Hold forever; the counter only records the first undriven cycle.
        w_stateNext = HOLD;
        if (r_state == DRIVEN) begin
          w_cntNext = w_cntInc;
        end
      end else if (w_cntInc == CNT_LIMIT) begin
        w_heldNext  = DECAY_VALUE;
        w_stateNext = DECAYED;
        w_cntNext   = w_cntInc;
      end else begin
        w_stateNext = HOLD;
        w_cntNext   = w_cntInc;
      end
    end
  end

  // Node register. PRECHARGED and DECAYED fall through the comb logic
  // unchanged while undriven, which makes them sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= PRECHARGED;
      r_held  <= PRECHARGE_VALUE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_held  <= w_heldNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Load latch and stale flag. Both use the pre-edge node value and state,
  // so a load concurrent with a drive captures bus_value and never flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_latchValue <= 8'h00;
      r_latchValid <= 1'b0;
      r_staleLoad  <= 1'b0;
    end else begin
      if (bus.load) begin
        r_latchValue <= w_effective;
        r_latchValid <= 1'b1;
      end
      r_staleLoad <= bus.load && !bus.bus_driven && (r_state == DECAYED);
    end
  end

  assign bus.effective_value = w_effective;
  assign bus.latch_value     = r_latchValue;
  assign bus.latch_valid     = r_latchValid;
  assign bus.node_state      = r_state;
  assign bus.stale_load      = r_staleLoad;

endmodule
